// File: rtl/ccu_if.sv
// Command/control-word bundle between the host command path and the ccu.
interface ccu_if;
  logic [7:0]  cmd;
  logic [23:0] Kbus;

  modport master (output cmd, input  Kbus);
  modport slave  (input  cmd, output Kbus);
endinterface

// File: rtl/ccu.sv
// Command Control Unit: registered one-hot decode of the command byte onto Kbus.
// Optional build macro CCU_HOLD_ILLEGAL_EN holds the last legal word on illegal commands.
module ccu (
  input  logic clk,
  input  logic rst_n,
  ccu_if.slave bus
);

  logic [22:0] strobe;
  logic        legal;
  logic [23:0] kbus_q;

  // One branch per opcode so per-opcode control fields can be added later.
  always_comb begin
    strobe = '0;
    legal  = 1'b0;
    if (!bus.cmd[0]) begin
      legal = 1'b1;
      case (bus.cmd[7:1])
        7'd0:    strobe = 23'h000001;
        7'd1:    strobe = 23'h000002;
        7'd2:    strobe = 23'h000004;
        7'd3:    strobe = 23'h000008;
        7'd4:    strobe = 23'h000010;
        7'd5:    strobe = 23'h000020;
        7'd6:    strobe = 23'h000040;
        7'd7:    strobe = 23'h000080;
        7'd8:    strobe = 23'h000100;
        7'd9:    strobe = 23'h000200;
        7'd10:   strobe = 23'h000400;
        7'd11:   strobe = 23'h000800;
        7'd12:   strobe = 23'h001000;
        7'd13:   strobe = 23'h002000;
        7'd14:   strobe = 23'h004000;
        7'd15:   strobe = 23'h008000;
        7'd16:   strobe = 23'h010000;
        7'd17:   strobe = 23'h020000;
        7'd18:   strobe = 23'h040000;
        7'd19:   strobe = 23'h080000;
        7'd20:   strobe = 23'h100000;
        7'd21:   strobe = 23'h200000;
        7'd22:   strobe = 23'h400000;
        default: legal  = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kbus_q <= '0;
    end else if (legal) begin
      kbus_q <= {1'b1, strobe};
    end else begin
`ifdef CCU_HOLD_ILLEGAL_EN
      kbus_q <= kbus_q;
`else
      kbus_q <= '0;
`endif
    end
  end

  assign bus.Kbus = kbus_q;

endmodule

// File: tb/tb_ccu.sv
// Scoreboard bench for ccu: driver queues expected Kbus words, monitor checks them after each edge.
module tb_ccu;

  logic clk;
  logic rst_n;
  ccu_if bus ();

  ccu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [23:0] exp;
    logic        legal;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] ill(input logic [23:0] held);
`ifdef CCU_HOLD_ILLEGAL_EN
    return held;
`else
    return 24'h000000;
`endif
  endfunction

  task automatic step(input logic rst, input logic [7:0] c, input logic [23:0] e,
                      input logic lg, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n   = rst;
    bus.cmd = c;
    x.exp   = e;
    x.legal = lg;
    x.name  = nm;
    q.push_back(x);
  endtask

  // Monitor: one word per edge, sampled 1 time unit after the rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (bus.Kbus !== x.exp) begin
          errors++;
          $display("FAIL %s: Kbus=%h expected=%h", x.name, bus.Kbus, x.exp);
        end
        if (x.legal) begin
          checks++;
          if ($countones(bus.Kbus) != 2) begin
            errors++;
            $display("FAIL %s onehot: bits set=%0d expected=2", x.name, $countones(bus.Kbus));
          end
        end
      end
    end
  end

  initial begin
    logic [23:0] held;
    logic [23:0] e;
    logic        lg;
    logic [6:0]  idx;
    int unsigned guard;
    checks = 0;
    errors = 0;
    rst_n   = 1'b0;
    bus.cmd = 8'd0;

    // Reset then legal ramp 2..26
    step(1'b0, 8'd2, 24'h000000, 1'b0, "reset");
    for (int unsigned c = 2; c <= 26; c += 2)
      step(1'b1, 8'(c), 24'h800000 | (24'h1 << (c / 2)), 1'b1, "ramp");

    // Range boundaries
    step(1'b1, 8'd0,  24'h800001, 1'b1, "cmd0");
    step(1'b1, 8'd44, 24'hC00000, 1'b1, "cmd44");
    step(1'b1, 8'd46, ill(24'hC00000), 1'b0, "cmd46");

    // Illegal codes after a legal 10
    step(1'b1, 8'd10, 24'h800020, 1'b1, "cmd10a");
    step(1'b1, 8'd76, ill(24'h800020), 1'b0, "cmd76");
    step(1'b1, 8'd10, 24'h800020, 1'b1, "cmd10b");
    step(1'b1, 8'd3,  ill(24'h800020), 1'b0, "cmd3");

    // Mid-stream reset
    step(1'b1, 8'd12, 24'h800040, 1'b1, "pre_rst");
    step(1'b0, 8'd14, 24'h000000, 1'b0, "mid_rst");
    step(1'b1, 8'd14, 24'h800080, 1'b1, "post_rst");

    // Coincident change: the edge must still see the pre-edge value 16
    step(1'b1, 8'd16, 24'h800100, 1'b1, "coinc16");
    @(posedge clk);
    bus.cmd <= 8'd18;
    step(1'b1, 8'd18, 24'h800200, 1'b1, "coinc18");

    // Exhaustive sweep after a fresh reset
    step(1'b0, 8'd0, 24'h000000, 1'b0, "sweep_rst");
    held = 24'h000000;
    for (int unsigned c = 0; c < 256; c++) begin
      idx = 7'(c >> 1);
      lg  = (c % 2 == 0) && (idx <= 7'd22);
      e   = lg ? (24'h800000 | (24'h1 << idx)) : ill(held);
      held = e;
      step(1'b1, 8'(c), e, lg, "sweep");
    end

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
